usb_pulpino_byte_streamer: RTL and testbench

- Downstream of the USB register file, upstream of the PULPino GPIO input bits.
- Buffers 32-bit words written by the host into a small FIFO.
- Serialises each word into bytes on the GPIO data-in byte, using the 2-bit turn-counter handshake that firmware polls.
- Runs entirely in the PULPino clock domain; the register side presents words already synchronised to that clock.

---
 rtl/usb_pulpino_byte_streamer_if.sv | 35 +++
 rtl/usb_pulpino_byte_streamer.sv | 173 +++++++++++++++++
 tb/tb_usb_pulpino_byte_streamer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pulpino_byte_streamer_if.sv
// Bus bundle between the USB register side and the PULPino GPIO byte channel.
// The slave modport is the streamer's view; the master modport drives it.
interface usb_pulpino_byte_streamer_if #(
    parameter int unsigned pDEPTH_LOG2 = 3
);
    // Word input from the register file plus control levels
    logic                   wr_valid_i;
    logic [31:0]            wr_data_i;
    logic                   flush_i;
    logic                   data_in_done_i;
    // Firmware-side ack counter (gpio_out[9:8])
    logic [1:0]             data_in_pulpino_turn;
    // Producer side of the byte channel (gpio_in[9:0])
    logic [7:0]             gpio_data_in;
    logic [1:0]             data_in_io_turn;
    // Status
    logic                   stream_end_o;
    logic [pDEPTH_LOG2:0]   fifo_count_o;
    logic                   fifo_full_o;
    logic                   fifo_empty_o;
    logic                   overflow_o;
    logic                   busy_o;

    modport slave (
        input  wr_valid_i, wr_data_i, flush_i, data_in_done_i, data_in_pulpino_turn,
        output gpio_data_in, data_in_io_turn, stream_end_o, fifo_count_o, fifo_full_o,
               fifo_empty_o, overflow_o, busy_o
    );

    modport master (
        output wr_valid_i, wr_data_i, flush_i, data_in_done_i, data_in_pulpino_turn,
        input  gpio_data_in, data_in_io_turn, stream_end_o, fifo_count_o, fifo_full_o,
               fifo_empty_o, overflow_o, busy_o
    );
endinterface

// File: rtl/usb_pulpino_byte_streamer.sv
// Word FIFO plus byte serialiser feeding the PULPino GPIO input byte.
// Each byte is published with a 2-bit turn counter; firmware acks by copying
// the counter back, and the channel is free whenever the two counters match.
module usb_pulpino_byte_streamer #(
    parameter int unsigned pDEPTH_LOG2 = 3,
    parameter bit          pLSB_FIRST  = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset_i,
    usb_pulpino_byte_streamer_if.slave     bus
);
    localparam int unsigned cDEPTH = 1 << pDEPTH_LOG2;
    localparam logic [pDEPTH_LOG2:0]   cCNT_ONE = (pDEPTH_LOG2 + 1)'(1);
    localparam logic [pDEPTH_LOG2-1:0] cPTR_ONE = pDEPTH_LOG2'(1);

    typedef enum logic [1:0] {StIdle, StPresent, StWaitAck} state_e;

    state_e                 r_state;
    state_e                 w_state_next;

    logic [31:0]            r_mem [cDEPTH];
    logic [pDEPTH_LOG2-1:0] r_wr_ptr;
    logic [pDEPTH_LOG2-1:0] r_rd_ptr;
    logic [pDEPTH_LOG2:0]   r_count;
    logic                   r_overflow;

    logic [31:0]            r_shift;
    logic [1:0]             r_byte_idx;
    logic [7:0]             r_gpio;
    logic [1:0]             r_io_turn;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_chan_free;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_present;
    logic                   w_advance;
    logic [31:0]            w_head;
    logic [31:0]            w_shifted;
    logic [7:0]             w_sel_byte;

    // Count can reach depth, so its MSB alone marks full
    assign w_empty     = (r_count == '0);
    assign w_full      = r_count[pDEPTH_LOG2];
    assign w_chan_free = (bus.data_in_pulpino_turn == r_io_turn);
    assign w_head      = r_mem[r_rd_ptr];

    // State register
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        if (bus.flush_i) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        w_state_next = StPresent;
                    end
                end
                StPresent: begin
                    w_state_next = StWaitAck;
                end
                StWaitAck: begin
                    if (w_chan_free) begin
                        w_state_next = (r_byte_idx == 2'd3) ? StIdle : StPresent;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    // FSM-decoded strobes and the byte/shift selection
    always_comb begin
        // Never pop while firmware still owes an ack, so a stale ack cannot skip a word
        w_pop     = (r_state == StIdle) && !w_empty && w_chan_free && !bus.flush_i;
        w_present = (r_state == StPresent) && !bus.flush_i;
        w_advance = (r_state == StWaitAck) && w_chan_free && (r_byte_idx != 2'd3)
                    && !bus.flush_i;
        // A write into a full FIFO still lands if the head leaves on the same edge
        w_push    = bus.wr_valid_i && !bus.flush_i && (!w_full || w_pop);
        w_drop    = bus.wr_valid_i && !bus.flush_i && w_full && !w_pop;
        if (pLSB_FIRST) begin
            w_sel_byte = r_shift[7:0];
            w_shifted  = {8'h00, r_shift[31:8]};
        end else begin
            w_sel_byte = r_shift[31:24];
            w_shifted  = {r_shift[23:0], 8'h00};
        end
    end

    // FIFO storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data_i;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + cPTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + cPTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cCNT_ONE;
                2'b01:   r_count <= r_count - cCNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Serialiser datapath; flush leaves gpio/io_turn alone so firmware stays in step
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_gpio     <= '0;
            r_io_turn  <= '0;
        end else begin
            if (w_pop) begin
                r_shift    <= w_head;
                r_byte_idx <= 2'd0;
            end else if (w_advance) begin
                r_shift    <= w_shifted;
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (w_present) begin
                r_gpio    <= w_sel_byte;
                r_io_turn <= r_io_turn + 2'd1;
            end
        end
    end

    assign bus.gpio_data_in    = r_gpio;
    assign bus.data_in_io_turn = r_io_turn;
    assign bus.stream_end_o    = bus.data_in_done_i && w_empty && (r_state == StIdle);
    assign bus.fifo_count_o    = r_count;
    assign bus.fifo_full_o     = w_full;
    assign bus.fifo_empty_o    = w_empty;
    assign bus.overflow_o      = r_overflow;
    assign bus.busy_o          = (r_state != StIdle);

endmodule

// File: tb/tb_usb_pulpino_byte_streamer.sv
// Bench for usb_pulpino_byte_streamer: an LSB-first and an MSB-first instance
// receive identical stimulus; firmware acks are played by the bench.
module tb_usb_pulpino_byte_streamer;
    localparam int unsigned cDL = 3;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    usb_pulpino_byte_streamer_if #(.pDEPTH_LOG2(cDL)) bus0 ();
    usb_pulpino_byte_streamer_if #(.pDEPTH_LOG2(cDL)) bus1 ();

    assign bus1.wr_valid_i           = bus0.wr_valid_i;
    assign bus1.wr_data_i            = bus0.wr_data_i;
    assign bus1.flush_i              = bus0.flush_i;
    assign bus1.data_in_done_i       = bus0.data_in_done_i;
    assign bus1.data_in_pulpino_turn = bus0.data_in_pulpino_turn;

    usb_pulpino_byte_streamer #(.pDEPTH_LOG2(cDL), .pLSB_FIRST(1'b1)) u_lsb (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus0)
    );

    usb_pulpino_byte_streamer #(.pDEPTH_LOG2(cDL), .pLSB_FIRST(1'b0)) u_msb (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus1)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_lsb;   // bytes in send order, first byte in [31:24]
        logic [31:0] exp_msb;
    } vec_t;

    vec_t        vecs [3];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  mturn;
    logic [31:0] w3 [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_word(input logic [31:0] w);
        bus0.wr_valid_i = 1'b1;
        bus0.wr_data_i  = w;
        tick();
        bus0.wr_valid_i = 1'b0;
    endtask

    task automatic ack();
        bus0.data_in_pulpino_turn = mturn;
    endtask

    // Wait (bounded) for the next turn; exp_lat 0 skips the latency comparison
    task automatic get_byte(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input int exp_lat);
        int lat;
        mturn = mturn + 2'd1;
        lat = 0;
        while (bus0.data_in_io_turn !== mturn && lat < 200) begin
            tick();
            lat++;
        end
        check({name, " io_turn"}, 32'(bus0.data_in_io_turn), 32'(mturn));
        check({name, " byte"}, 32'(bus0.gpio_data_in), 32'(e0));
        check({name, " msb-first byte"}, 32'(bus1.gpio_data_in), 32'(e1));
        if (exp_lat > 0) check({name, " latency"}, lat, exp_lat);
    endtask

    // Receive and ack all four bytes of a word
    task automatic drain_word(input string name, input logic [31:0] w, input int lat0);
        for (int b = 0; b < 4; b++) begin
            get_byte(name, w[8*b +: 8], w[31-8*b -: 8], (b == 0) ? lat0 : 2);
            tick();
            ack();
        end
    endtask

    task automatic check_reset(input string name);
        check({name, " gpio"}, 32'(bus0.gpio_data_in), 0);
        check({name, " io_turn"}, 32'(bus0.data_in_io_turn), 0);
        check({name, " stream_end"}, 32'(bus0.stream_end_o), 0);
        check({name, " count"}, 32'(bus0.fifo_count_o), 0);
        check({name, " full"}, 32'(bus0.fifo_full_o), 0);
        check({name, " empty"}, 32'(bus0.fifo_empty_o), 1);
        check({name, " overflow"}, 32'(bus0.overflow_o), 0);
        check({name, " busy"}, 32'(bus0.busy_o), 0);
        check({name, " msb gpio"}, 32'(bus1.gpio_data_in), 0);
        check({name, " msb io_turn"}, 32'(bus1.data_in_io_turn), 0);
    endtask

    initial begin
        vecs[0] = '{word: 32'hA1B2C3D4, exp_lsb: 32'hD4C3B2A1, exp_msb: 32'hA1B2C3D4};
        vecs[1] = '{word: 32'h11223344, exp_lsb: 32'h44332211, exp_msb: 32'h11223344};
        vecs[2] = '{word: 32'h00FF807F, exp_lsb: 32'h7F80FF00, exp_msb: 32'h00FF807F};
        for (int i = 0; i < 9; i++) w3[i] = 32'h10203040 + 32'(i);

        bus0.wr_valid_i           = 1'b0;
        bus0.wr_data_i            = '0;
        bus0.flush_i              = 1'b0;
        bus0.data_in_done_i       = 1'b0;
        bus0.data_in_pulpino_turn = 2'd0;
        mturn   = 2'd0;
        reset_i = 1'b1;
        ticks(2);
        check_reset("por");
        @(negedge clk);
        reset_i = 1'b0;

        // Single words, ack one cycle after each turn change, both byte orders
        for (int v = 0; v < 3; v++) begin
            logic [31:0] el;
            logic [31:0] em;
            el = vecs[v].exp_lsb;
            em = vecs[v].exp_msb;
            write_word(vecs[v].word);
            for (int b = 0; b < 4; b++) begin
                get_byte($sformatf("vec%0d b%0d", v, b), el[31-8*b -: 8], em[31-8*b -: 8], 2);
                tick();
                ack();
            end
            ticks(3);
            check($sformatf("vec%0d busy after", v), 32'(bus0.busy_o), 0);
            check($sformatf("vec%0d empty after", v), 32'(bus0.fifo_empty_o), 1);
        end

        // Ack withheld on byte 1 for 50 cycles while another word waits
        write_word(32'hA1B2C3D4);
        get_byte("hold b0", 8'hD4, 8'hA1, 2);
        tick();
        ack();
        get_byte("hold b1", 8'hC3, 8'hB2, 2);
        write_word(32'h55667788);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("hold gpio", 32'(bus0.gpio_data_in), 32'hC3);
            check("hold io_turn", 32'(bus0.data_in_io_turn), 32'(mturn));
        end
        check("hold no pop", 32'(bus0.fifo_count_o), 1);
        ack();
        get_byte("hold b2", 8'hB2, 8'hC3, 2);
        tick();
        ack();
        get_byte("hold b3", 8'hA1, 8'hD4, 2);
        tick();
        ack();
        drain_word("hold w1", 32'h55667788, 3);
        ticks(3);
        check("hold empty after", 32'(bus0.fifo_empty_o), 1);

        // Fill to full while a byte is unacked, overflow, then push+pop when full
        begin
            logic [31:0] wa;
            wa = 32'hCAFEBABE;
            write_word(wa);
            get_byte("fill wa b0", wa[7:0], wa[31:24], 2);
            for (int i = 0; i < 9; i++) begin
                write_word(w3[i]);
                if (i == 7) begin
                    check("fill count 8", 32'(bus0.fifo_count_o), 8);
                    check("fill full", 32'(bus0.fifo_full_o), 1);
                    check("fill no overflow yet", 32'(bus0.overflow_o), 0);
                end
            end
            check("fill overflow", 32'(bus0.overflow_o), 1);
            check("fill count held", 32'(bus0.fifo_count_o), 8);
            for (int b = 1; b < 4; b++) begin
                tick();
                ack();
                get_byte($sformatf("fill wa b%0d", b), wa[8*b +: 8], wa[31-8*b -: 8], 2);
            end
            tick();
            ack();
            tick();
            check("fill idle before pop", 32'(bus0.busy_o), 0);
            write_word(32'h99AABBCC);
            check("fill push+pop count", 32'(bus0.fifo_count_o), 8);
            check("fill push+pop full", 32'(bus0.fifo_full_o), 1);
            check("fill push+pop busy", 32'(bus0.busy_o), 1);
            for (int i = 0; i < 8; i++) begin
                drain_word($sformatf("fill w%0d", i), w3[i], (i == 0) ? 1 : 3);
            end
            drain_word("fill wx", 32'h99AABBCC, 3);
            ticks(3);
            check("fill empty after", 32'(bus0.fifo_empty_o), 1);
        end

        // Flush after byte 2 of a word with three words queued
        write_word(32'h0A0B0C0D);
        write_word(32'h31323334);
        write_word(32'h41424344);
        write_word(32'h51525354);
        get_byte("flush b0", 8'h0D, 8'h0A, 0);
        tick();
        ack();
        get_byte("flush b1", 8'h0C, 8'h0B, 2);
        tick();
        ack();
        get_byte("flush b2", 8'h0B, 8'h0C, 2);
        check("pre-flush count", 32'(bus0.fifo_count_o), 3);
        check("pre-flush overflow", 32'(bus0.overflow_o), 1);
        bus0.flush_i    = 1'b1;
        bus0.wr_valid_i = 1'b1;
        bus0.wr_data_i  = 32'hDEADBEEF;
        tick();
        bus0.flush_i    = 1'b0;
        bus0.wr_valid_i = 1'b0;
        check("flush count", 32'(bus0.fifo_count_o), 0);
        check("flush empty", 32'(bus0.fifo_empty_o), 1);
        check("flush overflow", 32'(bus0.overflow_o), 0);
        check("flush busy", 32'(bus0.busy_o), 0);
        check("flush io_turn kept", 32'(bus0.data_in_io_turn), 32'(mturn));
        check("flush gpio kept", 32'(bus0.gpio_data_in), 32'h0B);
        write_word(32'h11223344);
        ticks(3);
        check("lagging fw no pop", 32'(bus0.fifo_count_o), 1);
        check("lagging fw io_turn", 32'(bus0.data_in_io_turn), 32'(mturn));
        check("lagging fw busy", 32'(bus0.busy_o), 0);
        ack();
        drain_word("post-flush", 32'h11223344, 2);
        ticks(3);

        // stream_end with data_in_done high and two words queued
        bus0.data_in_done_i = 1'b1;
        tick();
        check("end idle", 32'(bus0.stream_end_o), 1);
        write_word(32'h61626364);
        check("end after push", 32'(bus0.stream_end_o), 0);
        write_word(32'h71727374);
        for (int b = 0; b < 8; b++) begin
            logic [31:0] w;
            int          bi;
            w  = (b < 4) ? 32'h61626364 : 32'h71727374;
            bi = b % 4;
            get_byte($sformatf("end b%0d", b), w[8*bi +: 8], w[31-8*bi -: 8],
                     (b == 0) ? 0 : ((bi == 0) ? 3 : 2));
            check($sformatf("end low b%0d", b), 32'(bus0.stream_end_o), 0);
            tick();
            ack();
        end
        check("end before last ack edge", 32'(bus0.stream_end_o), 0);
        tick();
        check("end asserted", 32'(bus0.stream_end_o), 1);
        check("end busy", 32'(bus0.busy_o), 0);
        write_word(32'h81828384);
        check("end dropped by write", 32'(bus0.stream_end_o), 0);
        bus0.data_in_done_i = 1'b0;

        // Asynchronous reset mid WAIT_ACK, between clock edges
        get_byte("arst b0", 8'h84, 8'h81, 2);
        #3;
        reset_i = 1'b1;
        #1;
        check_reset("async");
        tick();
        @(negedge clk);
        reset_i                   = 1'b0;
        mturn                     = 2'd0;
        bus0.data_in_pulpino_turn = 2'd0;
        write_word(32'hA1B2C3D4);
        get_byte("after reset b0", 8'hD4, 8'hA1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
